// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Requester-side bus of the data-memory arbiter. It carries both request
//   ports (0 = load/store unit, 1 = loader/debug) and the shared response
//   signals.
//   master : requester view (drives req/we/addr/wdata, sees gnt/rvalid/rdata/err/busy)
//   slave  : arbiter view
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter and sequencer for the word-addressed data
//   memory. After reset it spends one cycle clearing the array. It then
//   serves one access at a time in three cycles: grant, memory access, and
//   response.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus (slave)   : requester ports 0/1, grants, completion strobes,
//                   shared rdata/err, busy
//   mem_cs        : memory chip select
//   mem_reset     : memory synchronous clear
//   mem_re/mem_we : memory read / write enable
//   mem_addr      : memory word address
//   mem_wdata     : memory write data
//   mem_rdata     : memory read data (high-Z unless read-enabled)
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     bus,
  output logic              mem_cs,
  output logic              mem_reset,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic [1:0]        state, state_next;
  logic              ptr;        // 0: port 0 wins a tie, 1: port 1 wins
  logic              cmd_port;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              both_req;
  logic              in_range;
  logic              granted;

  assign both_req = bus.req0 & bus.req1;
  assign in_range = (cmd_addr < LIMIT);
  assign granted  = bus.gnt0 | bus.gnt1;

  // Grants come straight from the requests, but only while IDLE.
  always_comb begin
    // NOTE: default every output first so no path through this block
    // leaves a signal unassigned, which would infer a latch.
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    if (state == ST_IDLE) begin
      if (both_req) begin
        bus.gnt0 = ~ptr;
        bus.gnt1 = ptr;
      end else begin
        bus.gnt0 = bus.req0;
        bus.gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_IDLE;
      ST_IDLE:   if (granted) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and block order cannot create races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      ptr       <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_next;
      if (granted) begin
        cmd_port  <= bus.gnt1;
        cmd_we    <= bus.gnt1 ? bus.we1    : bus.we0;
        cmd_addr  <= bus.gnt1 ? bus.addr1  : bus.addr0;
        cmd_wdata <= bus.gnt1 ? bus.wdata1 : bus.wdata0;
      end
      // The pointer moves only when a tie was actually broken.
      if (state == ST_IDLE && both_req) ptr <= ~ptr;
      // mem_rdata is sampled only while the memory drives it.
      if (state == ST_ACCESS && in_range && !cmd_we) rdata_q <= mem_rdata;
    end
  end

  // Response side is decoded from state and the command register.
  assign bus.rvalid0 = (state == ST_RESP) & ~cmd_port;
  assign bus.rvalid1 = (state == ST_RESP) &  cmd_port;
  assign bus.err     = (state == ST_RESP) & ~in_range;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state != ST_IDLE);

  // INIT is also the state held during reset. Gating with reset_n keeps the
  // clear strobe low until reset is released, so the clear happens exactly
  // once, in the cycle after release.
  assign mem_reset = (state == ST_INIT) & reset_n;
  assign mem_cs    = mem_reset | ((state == ST_ACCESS) & in_range);
  assign mem_we    = (state == ST_ACCESS) & in_range &  cmd_we;
  assign mem_re    = (state == ST_ACCESS) & in_range & ~cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. It models the data memory, drives
//   both requester ports, and compares results against a word-array reference
//   model with a round-robin tie-break rule.
module tb_dmem_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 512;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic              mem_cs, mem_reset, mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  wire  [DATA_W-1:0] mem_rdata;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_reset (mem_reset),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Physical memory: synchronous clear/write, combinational tri-state read.
  logic [DATA_W-1:0] phys [DEPTH];
  always @(posedge clk) begin
    if (mem_cs && mem_reset) begin
      for (int i = 0; i < DEPTH; i++) phys[i] <= '0;
    end else if (mem_cs && mem_we && mem_addr < ADDR_W'(DEPTH)) begin
      phys[mem_addr[AW-1:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_cs && mem_re && mem_addr < ADDR_W'(DEPTH)) ?
                     phys[mem_addr[AW-1:0]] : {DATA_W{1'bz}};

  // Reference model.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_rdata;
  bit                ptr_model;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic ref_clear();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    ref_rdata = '0;
    ptr_model = 1'b0;
  endtask

  function automatic void ref_access(input bit we, input logic [ADDR_W-1:0] a,
                                     input logic [DATA_W-1:0] d, output logic er);
    er = (a >= ADDR_W'(DEPTH));
    if (!er) begin
      if (we) ref_mem[a[AW-1:0]] = d;
      else    ref_rdata = ref_mem[a[AW-1:0]];
    end
  endfunction

  task automatic drive(input bit port, input logic rq, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (port) begin bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else      begin bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
  endtask

  // One transaction on one port. Returns grant wait, the ACCESS-cycle view
  // {mem_cs, mem_we, mem_re, busy} with address/data, and the RESP-cycle
  // view {rvalid0, rvalid1, err} with rdata. Inputs are scrambled after grant.
  task automatic run_txn(input bit port, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int wt,
                         output logic [3:0] acc, output logic [ADDR_W-1:0] acc_a,
                         output logic [DATA_W-1:0] acc_d, output logic [2:0] resp,
                         output logic [DATA_W-1:0] rd);
    wt = 0;
    @(negedge clk);
    drive(port, 1'b1, we, a, d);
    #1;
    while (!(port ? bus.gnt1 : bus.gnt0) && wt < 20) begin
      @(negedge clk); #1; wt++;
    end
    @(negedge clk);
    drive(port, 1'b0, 1'($urandom), $urandom, $urandom);
    #1;
    acc = {mem_cs, mem_we, mem_re, bus.busy};
    acc_a = mem_addr;
    acc_d = mem_wdata;
    @(negedge clk); #1;
    resp = {bus.rvalid0, bus.rvalid1, bus.err};
    rd = bus.rdata;
  endtask

  task automatic write_word(input bit port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int wt; logic [3:0] acc; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad, rd; logic [2:0] rs; logic er;
    run_txn(port, 1'b1, a, d, wt, acc, aa, ad, rs, rd);
    ref_access(1'b1, a, d, er);
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b0, 32'd7, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_cs, mem_reset, mem_re, mem_we, bus.busy} !== 10'b0000000001) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000001",
        {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_cs, mem_reset, mem_re, mem_we, bus.busy});
    end
    n_cmp++;
    if ({bus.rdata, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0", bus.rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ref_clear();
    #1;
    n_cmp++;
    if ({mem_cs, mem_reset, bus.busy, bus.gnt0} !== 4'b1110) begin
      n_bad++; $display("FAIL init_cycle: got %b want 1110", {mem_cs, mem_reset, bus.busy, bus.gnt0});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_cs, mem_reset, bus.busy, bus.gnt0} !== 4'b0001) begin
      n_bad++; $display("FAIL first_grant: got %b want 0001", {mem_cs, mem_reset, bus.busy, bus.gnt0});
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if ({mem_cs, mem_re, mem_we, mem_addr} !== {3'b110, 32'd7}) begin
      n_bad++; $display("FAIL first_access: got %b/%0d want 110/7", {mem_cs, mem_re, mem_we}, mem_addr);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.rvalid0, bus.rvalid1, bus.err, bus.rdata} !== {3'b100, 32'd0}) begin
      n_bad++; $display("FAIL first_resp: got %b/%h want 100/0", {bus.rvalid0, bus.rvalid1, bus.err}, bus.rdata);
    end
  endtask

  task automatic test_init_clear();
    int wt, cnt; logic [3:0] acc; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad, rd; logic [2:0] rs; logic er;
    write_word(0, 32'd5, 32'hDEAD_BEEF);
    run_txn(0, 1'b0, 32'd5, '0, wt, acc, aa, ad, rs, rd);
    ref_access(1'b0, 32'd5, '0, er);
    n_cmp++;
    if (rd !== ref_rdata) begin n_bad++; $display("FAIL pre_clear_read: got %h want %h", rd, ref_rdata); end
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    ref_clear();
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1; if (mem_cs && mem_reset) cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 1) begin n_bad++; $display("FAIL init_count: got %0d want 1", cnt); end
    run_txn(0, 1'b0, 32'd5, '0, wt, acc, aa, ad, rs, rd);
    ref_access(1'b0, 32'd5, '0, er);
    n_cmp++;
    if (rd !== ref_rdata) begin n_bad++; $display("FAIL post_clear_read: got %h want %h", rd, ref_rdata); end
  endtask

  task automatic test_single();
    int wt; logic [3:0] acc; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad, rd; logic [2:0] rs; logic er;
    run_txn(0, 1'b1, 32'd10, 32'h1234_5678, wt, acc, aa, ad, rs, rd);
    ref_access(1'b1, 32'd10, 32'h1234_5678, er);
    n_cmp++;
    if (wt != 0 || acc !== 4'b1101 || aa !== 32'd10 || ad !== 32'h1234_5678 || rs !== 3'b100) begin
      n_bad++; $display("FAIL single_write: got wait=%0d acc=%b a=%0d d=%h resp=%b want 0/1101/10/12345678/100",
                        wt, acc, aa, ad, rs);
    end
    run_txn(0, 1'b0, 32'd10, '0, wt, acc, aa, ad, rs, rd);
    ref_access(1'b0, 32'd10, '0, er);
    n_cmp++;
    if (wt != 0 || acc !== 4'b1011 || rs !== 3'b100 || rd !== ref_rdata) begin
      n_bad++; $display("FAIL single_read: got wait=%0d acc=%b resp=%b d=%h want 0/1011/100/%h", wt, acc, rs, rd, ref_rdata);
    end
    run_txn(0, 1'b1, 32'd11, 32'hCAFE_0011, wt, acc, aa, ad, rs, rd);
    ref_access(1'b1, 32'd11, 32'hCAFE_0011, er);
    n_cmp++;
    if (rd !== ref_rdata) begin n_bad++; $display("FAIL rdata_hold_on_write: got %h want %h", rd, ref_rdata); end
  endtask

  task automatic test_random();
    int wt; logic [3:0] acc; logic [ADDR_W-1:0] aa, a; logic [DATA_W-1:0] ad, rd, d; logic [2:0] rs; logic er;
    bit p, w;
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom);
      w = 1'($urandom);
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(DEPTH, DEPTH + 64));
      else                           a = ADDR_W'($urandom_range(1, 48));
      run_txn(p, w, a, d, wt, acc, aa, ad, rs, rd);
      ref_access(w, a, d, er);
      n_cmp++;
      if (wt != 0 || acc[3:1] !== (er ? 3'b000 : {1'b1, w, !w}) || rs !== {!p, p, er}) begin
        n_bad++; $display("FAIL rnd_txn%0d: got wait=%0d acc=%b resp=%b want acc=%b resp=%b (port %0d addr %0d we %0d)",
                          i, wt, acc[3:1], rs, (er ? 3'b000 : {1'b1, w, !w}), {!p, p, er}, p, a, w);
      end
      if (!er) begin
        n_cmp++;
        if (rd !== ref_rdata || aa !== a || (w && ad !== d)) begin
          n_bad++; $display("FAIL rnd_data%0d: got rdata=%h addr=%0d want rdata=%h addr=%0d", i, rd, aa, ref_rdata, a);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int wt; logic [3:0] acc; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad, rd; logic [2:0] rs; logic er;
    run_txn(1, 1'b1, ADDR_W'(DEPTH), 32'hFFFF_FFFF, wt, acc, aa, ad, rs, rd);
    ref_access(1'b1, ADDR_W'(DEPTH), 32'hFFFF_FFFF, er);
    n_cmp++;
    if (acc[3:1] !== 3'b000 || rs !== 3'b011) begin
      n_bad++; $display("FAIL oor_write: got acc=%b resp=%b want 000/011", acc[3:1], rs);
    end
    run_txn(0, 1'b0, 32'd0, '0, wt, acc, aa, ad, rs, rd);
    ref_access(1'b0, 32'd0, '0, er);
    n_cmp++;
    if (rs !== 3'b100 || rd !== ref_rdata) begin
      n_bad++; $display("FAIL oor_alias: got resp=%b rdata=%h want 100/%h", rs, rd, ref_rdata);
    end
  endtask

  task automatic test_hold();
    logic er; logic [DATA_W-1:0] exp0, exp1;
    write_word(0, 32'd40, $urandom);
    write_word(0, 32'd41, $urandom);
    write_word(1, 32'd42, $urandom);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd40, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_bad++; $display("FAIL hold_gnt0: got %b want 10", {bus.gnt0, bus.gnt1}); end
    ref_access(1'b0, 32'd40, '0, er);
    exp0 = ref_rdata;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd41, '0);
    drive(1, 1'b1, 1'b0, 32'd42, '0);
    #1;
    n_cmp++;
    if ({mem_re, mem_addr, bus.gnt1} !== {1'b1, 32'd40, 1'b0}) begin
      n_bad++; $display("FAIL hold_addr: got re=%b addr=%0d gnt1=%b want 1/40/0", mem_re, mem_addr, bus.gnt1);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.rvalid0, bus.gnt1, bus.rdata} !== {2'b10, exp0}) begin
      n_bad++; $display("FAIL hold_resp0: got rv0=%b gnt1=%b rdata=%h want 1/0/%h", bus.rvalid0, bus.gnt1, bus.rdata, exp0);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.gnt1 !== 1'b1) begin n_bad++; $display("FAIL hold_gnt1: got %b want 1", bus.gnt1); end
    ref_access(1'b0, 32'd42, '0, er);
    exp1 = ref_rdata;
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b01, exp1}) begin
      n_bad++; $display("FAIL hold_resp1: got rv=%b rdata=%h want 01/%h", {bus.rvalid0, bus.rvalid1}, bus.rdata, exp1);
    end
  endtask

  typedef struct {
    int                cyc;
    bit                port;
    logic [DATA_W-1:0] data;
  } pend_t;

  task automatic test_contention();
    logic [ADDR_W-1:0] a0 [2];
    logic [ADDR_W-1:0] a1 [2];
    pend_t q[$];
    pend_t e;
    int k0, k1, grants, last;
    bit upd0, upd1, exp_p;
    logic er;
    a0 = '{32'd60, 32'd62};
    a1 = '{32'd61, 32'd63};
    k0 = 0; k1 = 0; grants = 0; last = -1; upd0 = 0; upd1 = 0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    ref_clear();
    for (int i = 60; i < 64; i++) write_word(0, ADDR_W'(i), $urandom);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, a0[0], '0);
    drive(1, 1'b1, 1'b0, a1[0], '0);
    for (int c = 0; c < 30 && !(grants == 4 && q.size() == 0); c++) begin
      if (c > 0) @(negedge clk);
      if (upd0) begin if (k0 < 2) bus.addr0 = a0[k0]; else bus.req0 = 1'b0; upd0 = 0; end
      if (upd1) begin if (k1 < 2) bus.addr1 = a1[k1]; else bus.req1 = 1'b0; upd1 = 0; end
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        if (bus.req0 && bus.req1) begin exp_p = ptr_model; ptr_model = !ptr_model; end
        else exp_p = bus.req1;
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== {!exp_p, exp_p} || (last >= 0 && c - last != 3)) begin
          n_bad++; $display("FAIL cont_grant%0d: got gnt=%b gap=%0d want gnt=%b gap=3",
                            grants, {bus.gnt0, bus.gnt1}, c - last, {!exp_p, exp_p});
        end
        ref_access(1'b0, exp_p ? a1[k1] : a0[k0], '0, er);
        e.cyc = c + 2; e.port = exp_p; e.data = ref_rdata;
        q.push_back(e);
        if (exp_p) begin k1++; upd1 = 1; end else begin k0++; upd0 = 1; end
        grants++;
        last = c;
      end
      if (q.size() > 0 && q[0].cyc == c) begin
        e = q.pop_front();
        n_cmp++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {!e.port, e.port, e.data}) begin
          n_bad++; $display("FAIL cont_resp: got rv=%b rdata=%h want rv=%b rdata=%h",
                            {bus.rvalid0, bus.rvalid1}, bus.rdata, {!e.port, e.port}, e.data);
        end
      end else if (bus.rvalid0 || bus.rvalid1) begin
        n_cmp++; n_bad++;
        $display("FAIL cont_spurious_rvalid: got rv=%b at cycle %0d want 00", {bus.rvalid0, bus.rvalid1}, c);
      end
    end
    n_cmp++;
    if (grants != 4 || q.size() != 0) begin
      n_bad++; $display("FAIL cont_done: got grants=%0d pending=%0d want 4/0", grants, q.size());
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_midop();
    int wt, rv_seen; logic [3:0] acc; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad, rd; logic [2:0] rs; logic er;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5);
    #1;
    n_cmp++;
    if (bus.gnt0 !== 1'b1) begin n_bad++; $display("FAIL midop_gnt: got %b want 1", bus.gnt0); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    n_cmp++;
    if ({mem_cs, mem_we} !== 2'b11) begin n_bad++; $display("FAIL midop_we: got %b want 11", {mem_cs, mem_we}); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_cs, mem_reset, mem_re, mem_we, bus.busy} !== 10'b0000000001
        || {bus.rdata, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL midop_async: got ctrl=%b rdata=%h addr=%h wdata=%h want 0000000001/0/0/0",
        {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_cs, mem_reset, mem_re, mem_we, bus.busy},
        bus.rdata, mem_addr, mem_wdata);
    end
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) begin reset_n = 1'b1; ref_clear(); end
      #1;
      if (bus.rvalid0 || bus.rvalid1) rv_seen++;
    end
    n_cmp++;
    if (rv_seen != 0) begin n_bad++; $display("FAIL midop_no_rvalid: got %0d strobes want 0", rv_seen); end
    run_txn(0, 1'b0, 32'd3, '0, wt, acc, aa, ad, rs, rd);
    ref_access(1'b0, 32'd3, '0, er);
    n_cmp++;
    if (rs !== 3'b100 || rd !== ref_rdata) begin
      n_bad++; $display("FAIL midop_read: got resp=%b rdata=%h want 100/%h", rs, rd, ref_rdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    ref_clear();
    test_reset();
    test_init_clear();
    test_single();
    test_random();
    test_out_of_range();
    test_hold();
    test_contention();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-cycle core's word-addressed data memory. Requester 0 is the core load/store unit; requester 1 is the program/data loader (or debug) port. The block runs one post-reset clear of the memory array, arbitrates round-robin between the two ports, and drives the memory's chip-select, read/write enables, address and write data. It returns read data and a completion strobe to the winning port.

## Interface
- `DATA_W`, default 32: data width.
- `ADDR_W`, default 32: address width; addresses are word indices.
- `DEPTH`, default 512: number of memory words; legal addresses are 0..DEPTH-1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: request from port 0 / port 1.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: word address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `gnt0` / `gnt1` out 1: command accepted this cycle.
- `rvalid0` / `rvalid1` out 1: one-cycle completion strobe, for reads and writes.
- `rdata` out DATA_W: read data, shared by both ports and valid with `rvalid*`.
- `err` out 1: the completing access was out of range; valid with `rvalid*`.
- `busy` out 1: state is not IDLE.
- `mem_cs` out 1: memory chip select.
- `mem_reset` out 1: memory synchronous clear.
- `mem_re` / `mem_we` out 1: memory read / write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; combinational, high-Z when the memory is not read-enabled.

## Operation
- States: INIT, IDLE, ACCESS, RESP.
- Reset (`reset_n`=0, asynchronous) sets:
  - state to INIT and the round-robin pointer to port 0;
  - `gnt*`, `rvalid*`, `err`, `mem_*` control outputs to 0;
  - `rdata`, `mem_addr`, `mem_wdata` to 0;
  - `busy`, which is decoded from state, to 1.
- INIT lasts exactly one cycle after reset release. It drives `mem_cs`=1 and `mem_reset`=1, which clears the array on the next edge. Then go to IDLE.
- IDLE arbitration:
  - If only one port requests, grant it.
  - If both request, grant the port the pointer favours; the pointer then moves to the other port.
  - The pointer changes only on a grant when both ports are requesting.
  - `gnt*` is combinational from `req*` and is asserted only in IDLE.
- On grant, latch `we`, `addr`, `wdata` and the port id into the command register, then go to ACCESS.
- The requester holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt`. It may change them freely after `gnt`.
- Requests arriving in INIT, ACCESS or RESP wait. They are not lost while held.
- ACCESS, in-range (`addr` < DEPTH):
  - `mem_cs`=1 and `mem_addr`/`mem_wdata` come from the command register.
  - `mem_we`=we and `mem_re`=!we.
  - On a read, `rdata` captures `mem_rdata` at the ACCESS→RESP edge. On a write, `rdata` holds its previous value.
- ACCESS, out-of-range: `mem_cs`, `mem_re`, `mem_we` stay 0, the memory is untouched, and `err` is set for RESP.
- RESP: pulse `rvalid` on the latched port for one cycle, then go to IDLE. `err` is valid only in RESP and is 0 otherwise.
- All `mem_*` outputs are decoded from state and the command register only; there is no combinational path from requester inputs. Outside INIT/ACCESS they are 0, with `mem_addr` and `mem_wdata` holding their last values.
- `mem_rdata` is never sampled outside ACCESS-read, so a high-Z bus is never captured.
- Reset asserted mid-transaction aborts it immediately. No `rvalid` is issued, an ACCESS write not yet clocked is dropped, and INIT repeats after release.

## Timing
- Cycle t, IDLE with `req`: `gnt`=1.
- Cycle t+1, ACCESS: memory enables are asserted. A write commits, or read data is captured, at the end of t+1.
- Cycle t+2, RESP: `rvalid`=1 and `rdata`/`err` are valid.
- Cycle t+3, IDLE: the next grant is possible.
- Throughput is one access per 3 cycles; under contention each port gets every other slot.
- After reset release: cycle 0 is INIT, and the earliest grant is cycle 1.

## Test plan
- **Init clear:** write 0xDEADBEEF to address 5, pulse `reset_n` low, then read address 5. Required:
  - exactly one INIT cycle with `mem_cs`=`mem_reset`=1;
  - the read returns 0.
- **Single-port write/read:**
  - Port 0 writes 0x12345678 to address 10. Required: `gnt0` at t, `mem_we`=1 at t+1, `rvalid0`=1 with `err`=0 at t+2.
  - Port 0 then reads address 10. Required: `rdata`=0x12345678 with `rvalid0` at t+2.
- **Contention:** hold `req0` and `req1` continuously from reset, each read of a distinct address. Required:
  - grant order 0,1,0,1;
  - grants 3 cycles apart;
  - each `rvalid` only on the granted port, with the correct data.
- **Out-of-range:** port 1 writes 0xFFFFFFFF to address 512. Required:
  - `mem_cs` stays 0;
  - `rvalid1`=1 with `err`=1;
  - a subsequent read of address 0 returns 0, so no aliasing.
- **Hold rules:** raise `req1` during port 0's ACCESS and change `addr0` in the cycle after `gnt0`. Required:
  - port 0's access uses the original address;
  - `gnt1` is asserted in the first IDLE cycle after `rvalid0`.
- **Reset mid-op:** drop `reset_n` during an ACCESS write to address 3. Required:
  - all outputs go to their reset values asynchronously;
  - no `rvalid`;
  - address 3 reads 0 after INIT.
